// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I core.
// Pipeline control encodings live here so every stage agrees on them.
package riscv_pkg;

  localparam int REG_AW = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    RUN,
    DWAIT
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN  = 8'b1010_1010;
  localparam ctrl_t CTRL_RST  = 8'b0001_0101;
  localparam ctrl_t CTRL_DST  = 8'b0000_0001;
  localparam ctrl_t CTRL_RED  = 8'b1111_1110;
  localparam ctrl_t CTRL_LU   = 8'b0000_1110;
  localparam ctrl_t CTRL_FW   = 8'b0011_1010;
  localparam ctrl_t CTRL_KILL = 8'b1011_1010;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between the ID operands and the EX load.
// Purely combinational; also shared with the forwarding unit.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] rs1_raddr,
  input  logic [REG_AW-1:0] rs2_raddr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd_waddr,
  input  logic              memread,
  output logic              hazard
);

  logic rd_nz;
  logic hit1;
  logic hit2;

  assign rd_nz  = |rd_waddr;
  assign hit1   = rs1_used & (rs1_raddr == rd_waddr);
  assign hit2   = rs2_used & (rs2_raddr == rd_waddr);
  assign hazard = memread & rd_nz & (hit1 | hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller: per-stage advance/hold/flush,
// stale-fetch kill tracking and saturating debug counters.
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_raddr,
  input  logic [REG_AW-1:0] rs2_raddr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd_waddr_EX,
  input  logic              memread_EX,
  input  logic              branch_taken_EX,
  input  logic              imem_req,
  input  logic              imem_ready,
  input  logic              dmem_req_MEM,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t state;
  state_t state_d;
  logic   kill_q;
  logic   kill_d;
  ctrl_t  ctrl;

  logic hazard;
  logic dstall;
  logic fwait;
  logic sel_dst;
  logic sel_red;
  logic sel_lu;
  logic sel_fw;
  logic sel_kill;

  hazard_detect u_hazard (
    .rs1_raddr (rs1_raddr),
    .rs2_raddr (rs2_raddr),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .rd_waddr  (rd_waddr_EX),
    .memread   (memread_EX),
    .hazard    (hazard)
  );

  assign dstall = dmem_req_MEM & ~dmem_ready;
  assign fwait  = imem_req & ~imem_ready;

  // One-hot priority selects so the decoder below stays unique
  assign sel_dst  = dstall;
  assign sel_red  = ~dstall & branch_taken_EX;
  assign sel_lu   = ~dstall & ~branch_taken_EX & hazard;
  assign sel_fw   = ~dstall & ~branch_taken_EX & ~hazard & fwait;
  assign sel_kill = ~dstall & ~branch_taken_EX & ~hazard & ~fwait
                  & imem_ready & kill_q;

  always_comb begin
    ctrl    = CTRL_RUN;
    kill_d  = kill_q;
    state_d = state;
    if (state == DWAIT && dmem_ready)
      state_d = RUN;
    unique case (1'b1)
      sel_dst: begin
        ctrl    = CTRL_DST;
        state_d = DWAIT;
      end
      sel_red: begin
        ctrl = CTRL_RED;
        // A stale return landing now is flushed by the redirect itself
        if (fwait)
          kill_d = 1'b1;
        else if (imem_ready)
          kill_d = 1'b0;
      end
      sel_lu: ctrl = CTRL_LU;
      sel_fw: ctrl = CTRL_FW;
      sel_kill: begin
        ctrl   = CTRL_KILL;
        kill_d = 1'b0;
      end
      default: ;
    endcase
    if (!rst_n)
      ctrl = CTRL_RST;
  end

  assign pc_en        = ctrl.pc_en;
  assign pc_redirect  = ctrl.pc_redirect;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      kill_q <= 1'b0;
    end else begin
      state  <= state_d;
      kill_q <= kill_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctrl.pc_en && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl.pc_redirect && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
